// File: rtl/nmos_pmos_pkg.sv
// Four-state value type and switch/node evaluation functions for nmos_pmos.
package nmos_pmos_pkg;

  typedef enum logic [1:0] {
    L0 = 2'b00,
    L1 = 2'b01,
    LZ = 2'b10,
    LX = 2'b11
  } logic4_t;

  localparam logic [1:0] RESET_LANE = LZ;

  // An unknown gate may or may not conduct, so a driven source becomes X.
  function automatic logic4_t nmos_eval(input logic4_t gate, input logic4_t data);
    logic4_t r;
    case (gate)
      L1:      r = data;
      L0:      r = LZ;
      default: r = (data == LZ) ? LZ : LX;
    endcase
    return r;
  endfunction

  function automatic logic4_t pmos_eval(input logic4_t gate, input logic4_t data);
    logic4_t r;
    case (gate)
      L0:      r = data;
      L1:      r = LZ;
      default: r = (data == LZ) ? LZ : LX;
    endcase
    return r;
  endfunction

  function automatic logic4_t resolve(input logic4_t a, input logic4_t b);
    logic4_t r;
    if (a == LZ)      r = b;
    else if (b == LZ) r = a;
    else if (a == b)  r = a;
    else              r = LX;
    return r;
  endfunction

endpackage

// File: rtl/nmos_pmos_if.sv
// Bus bundle for nmos_pmos; contention exists only with NMOS_PMOS_CONTENTION_EN.
interface nmos_pmos_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic [2*WIDTH-1:0] n_data;
  logic [2*WIDTH-1:0] n_gate;
  logic [2*WIDTH-1:0] p_data;
  logic [2*WIDTH-1:0] p_gate;
  logic               out_valid;
  logic [2*WIDTH-1:0] out;
`ifdef NMOS_PMOS_CONTENTION_EN
  logic [WIDTH-1:0]   contention;

  modport master (output in_valid, n_data, n_gate, p_data, p_gate,
                  input  out_valid, out, contention);
  modport slave  (input  in_valid, n_data, n_gate, p_data, p_gate,
                  output out_valid, out, contention);
`else
  modport master (output in_valid, n_data, n_gate, p_data, p_gate,
                  input  out_valid, out);
  modport slave  (input  in_valid, n_data, n_gate, p_data, p_gate,
                  output out_valid, out);
`endif
endinterface

// File: rtl/nmos_pmos_mos_lane.sv
// Combinational single-lane nmos/pmos pair; fight term with NMOS_PMOS_CONTENTION_EN.
module mos_lane
  import nmos_pmos_pkg::*;
(
  input  logic [1:0] n_data_i,
  input  logic [1:0] n_gate_i,
  input  logic [1:0] p_data_i,
  input  logic [1:0] p_gate_i,
`ifdef NMOS_PMOS_CONTENTION_EN
  output logic       fight_o,
`endif
  output logic [1:0] node_o
);

  logic4_t n_out;
  logic4_t p_out;
  logic4_t node;

  always_comb begin
    n_out = nmos_eval(logic4_t'(n_gate_i), logic4_t'(n_data_i));
    p_out = pmos_eval(logic4_t'(p_gate_i), logic4_t'(p_data_i));
    node  = resolve(n_out, p_out);
  end

  assign node_o = node;

`ifdef NMOS_PMOS_CONTENTION_EN
  assign fight_o = (n_out != LZ) && (p_out != LZ) && (node == LX);
`endif

endmodule

// File: rtl/nmos_pmos.sv
// Multi-lane registered nmos/pmos node model; NMOS_PMOS_CONTENTION_EN adds contention flags.
module nmos_pmos
  import nmos_pmos_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  nmos_pmos_if.slave  bus
);

  logic [2*WIDTH-1:0] node_d;
  logic [2*WIDTH-1:0] out_q;
  logic               out_valid_q;
`ifdef NMOS_PMOS_CONTENTION_EN
  logic [WIDTH-1:0]   fight_d;
  logic [WIDTH-1:0]   contention_q;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mos_lane u_lane (
      .n_data_i (bus.n_data[2*i +: 2]),
      .n_gate_i (bus.n_gate[2*i +: 2]),
      .p_data_i (bus.p_data[2*i +: 2]),
      .p_gate_i (bus.p_gate[2*i +: 2]),
`ifdef NMOS_PMOS_CONTENTION_EN
      .fight_o  (fight_d[i]),
`endif
      .node_o   (node_d[2*i +: 2])
    );
  end

  // Reset wins over in_valid; results hold while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= {WIDTH{RESET_LANE}};
      out_valid_q  <= 1'b0;
`ifdef NMOS_PMOS_CONTENTION_EN
      contention_q <= '0;
`endif
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q        <= node_d;
`ifdef NMOS_PMOS_CONTENTION_EN
        contention_q <= fight_d;
`endif
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
`ifdef NMOS_PMOS_CONTENTION_EN
  assign bus.contention = contention_q;
`endif

endmodule

// File: tb/tb_nmos_pmos.sv
// Self-checking bench for nmos_pmos against a set-based four-state model.
module tb_nmos_pmos;

  localparam int W = 8;

  logic clk;
  logic rst;

  nmos_pmos_if #(.WIDTH(W)) bus ();

  nmos_pmos #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_out;
  logic           exp_valid;
  logic [W-1:0]   exp_cont;

  // Value as set of possible levels: bit0 = may be 0, bit1 = may be 1, bit2 = may be Z.
  function automatic logic [2:0] to_set(input logic [1:0] v);
    case (v)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [2:0] sw_set(input logic [1:0] g, input logic [1:0] d,
                                        input logic [1:0] on_code);
    logic [2:0] s;
    if (g == on_code)           s = to_set(d);
    else if (g == (on_code ^ 2'b01)) s = 3'b100;
    else                        s = to_set(d) | 3'b100;
    // Possibly-driven-possibly-floating collapses to fully unknown.
    if (s[2] && s[1:0] != 2'b00) s = 3'b011;
    return s;
  endfunction

  task automatic model_lane(input logic [1:0] nd, ng, pd, pg,
                            output logic [1:0] res, output logic fight);
    logic [2:0] sa, sb;
    logic [1:0] drv;
    sa  = sw_set(ng, nd, 2'b01);
    sb  = sw_set(pg, pd, 2'b00);
    drv = sa[1:0] | sb[1:0];
    case (drv)
      2'b00:   res = 2'b10;
      2'b01:   res = 2'b00;
      2'b10:   res = 2'b01;
      default: res = 2'b11;
    endcase
    fight = (sa != 3'b100) && (sb != 3'b100) && (res == 2'b11);
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [2*W-1:0] nd, ng, pd, pg);
    logic [1:0] res;
    logic       f;
    rst = r;
    bus.in_valid = v;
    bus.n_data = nd;
    bus.n_gate = ng;
    bus.p_data = pd;
    bus.p_gate = pg;
    @(posedge clk);
    #1;
    if (r) begin
      exp_out   = {W{2'b10}};
      exp_valid = 1'b0;
      exp_cont  = '0;
    end else begin
      exp_valid = v;
      if (v) begin
        for (int i = 0; i < W; i++) begin
          model_lane(nd[2*i +: 2], ng[2*i +: 2], pd[2*i +: 2], pg[2*i +: 2], res, f);
          exp_out[2*i +: 2] = res;
          exp_cont[i]       = f;
        end
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
    checks++;
    if (bus.out !== 16'hAAAA) begin
      errors++; $display("FAIL reset_out got %h want %h", bus.out, 16'hAAAA);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid);
    end
`ifdef NMOS_PMOS_CONTENTION_EN
    checks++;
    if (bus.contention !== '0) begin
      errors++; $display("FAIL reset_cont got %h want 0", bus.contention);
    end
`endif
  endtask

  task automatic test_inverter();
    step(1'b0, 1'b1, {W{2'b00}}, {W{2'b01}}, {W{2'b01}}, {W{2'b01}});
    checks++;
    if (bus.out[1:0] !== 2'b00 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL inv_in1 got %b/%b want 00/1", bus.out[1:0], bus.out_valid);
    end
    step(1'b0, 1'b1, {W{2'b00}}, {W{2'b00}}, {W{2'b01}}, {W{2'b00}});
    checks++;
    if (bus.out !== {W{2'b01}} || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL inv_in0 got %h/%b want %h/1", bus.out, bus.out_valid, {W{2'b01}});
    end
  endtask

  task automatic test_both_off();
    step(1'b0, 1'b1, $urandom, {W{2'b00}}, $urandom, {W{2'b01}});
    checks++;
    if (bus.out !== {W{2'b10}}) begin
      errors++; $display("FAIL both_off got %h want %h", bus.out, {W{2'b10}});
    end
`ifdef NMOS_PMOS_CONTENTION_EN
    checks++;
    if (bus.contention !== '0) begin
      errors++; $display("FAIL both_off_cont got %h want 0", bus.contention);
    end
`endif
  endtask

  task automatic test_fight();
    step(1'b0, 1'b1, {W{2'b00}}, {W{2'b01}}, {W{2'b01}}, {W{2'b00}});
    checks++;
    if (bus.out !== {W{2'b11}}) begin
      errors++; $display("FAIL fight got %h want %h", bus.out, {W{2'b11}});
    end
`ifdef NMOS_PMOS_CONTENTION_EN
    checks++;
    if (bus.contention !== {W{1'b1}}) begin
      errors++; $display("FAIL fight_cont got %h want %h", bus.contention, {W{1'b1}});
    end
`endif
  endtask

  task automatic test_unknown_gate();
    step(1'b0, 1'b1, {W{2'b01}}, {W{2'b11}}, $urandom, {W{2'b01}});
    checks++;
    if (bus.out !== {W{2'b11}}) begin
      errors++; $display("FAIL xgate_d1 got %h want %h", bus.out, {W{2'b11}});
    end
    step(1'b0, 1'b1, {W{2'b10}}, {W{2'b11}}, $urandom, {W{2'b01}});
    checks++;
    if (bus.out !== {W{2'b10}}) begin
      errors++; $display("FAIL xgate_dz got %h want %h", bus.out, {W{2'b10}});
    end
    step(1'b0, 1'b1, {W{2'b10}}, {W{2'b10}}, {W{2'b00}}, {W{2'b10}});
    checks++;
    if (bus.out !== {W{2'b11}}) begin
      errors++; $display("FAIL zgate_both got %h want %h", bus.out, {W{2'b11}});
    end
  endtask

  task automatic test_hold();
    logic [2*W-1:0] held;
    step(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
    held = exp_out;
    checks++;
    if (bus.out !== held || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_load got %h/%b want %h/1", bus.out, bus.out_valid, held);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
      checks++;
      if (bus.out !== held || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL hold_c%0d got %h/%b want %h/0", c, bus.out, bus.out_valid, held);
      end
    end
  endtask

  task automatic test_midstream_reset();
    step(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
    step(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
    checks++;
    if (bus.out !== 16'hAAAA || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %h/%b want aaaa/0", bus.out, bus.out_valid);
    end
    step(1'b0, 1'b1, {W{2'b01}}, {W{2'b01}}, $urandom, {W{2'b01}});
    checks++;
    if (bus.out !== {W{2'b01}} || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset got %h/%b want %h/1", bus.out, bus.out_valid, {W{2'b01}});
    end
  endtask

  task automatic test_random();
    logic r, v;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, v, $urandom, $urandom, $urandom, $urandom);
      checks++;
      if (bus.out !== exp_out || bus.out_valid !== exp_valid) begin
        errors++;
        $display("FAIL rand_%0d got %h/%b want %h/%b", n, bus.out, bus.out_valid, exp_out, exp_valid);
      end
`ifdef NMOS_PMOS_CONTENTION_EN
      checks++;
      if (bus.contention !== exp_cont) begin
        errors++; $display("FAIL rand_cont_%0d got %h want %h", n, bus.contention, exp_cont);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom);
      checks++;
      if (bus.out !== exp_out || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d got %h/%b want %h/1", n, bus.out, bus.out_valid, exp_out);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.n_data = '0;
    bus.n_gate = '0;
    bus.p_data = '0;
    bus.p_gate = '0;
    exp_out = '0;
    exp_valid = 1'b0;
    exp_cont = '0;
    test_reset();
    test_inverter();
    test_both_off();
    test_fight();
    test_unknown_gate();
    test_hold();
    test_midstream_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
